// File: rtl/tt_host_pin_driver.sv
// ---------------------------------------------------------------------------------------------
// tt_host_pin_driver
//   Host-side driver for the 8-pin benchmark wrapper. Takes one command at a time (output
//   select, data bits, optional DUT reset, N clock pulses), builds the registered pin word
//   {sel, data, rst_n, dclk}, toggles the wrapper clock N times, then samples the wrapper
//   outputs and returns them over a valid/ready response channel.
//
// Parameters
//   CLK_DIV  clk cycles per half-period of the generated DUT clock (also SETUP settle time), >=1
//   CNT_W    width of the pulse count; max pulses per command = 2**CNT_W-1
//
// Ports
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   cmd_valid_i    command offered
//   cmd_ready_o    high only in idle; a command is accepted on cmd_valid_i & cmd_ready_o
//   cmd_sel_i      output select, drives dut_io_in_o[7:5]
//   cmd_data_i     data bits, drive dut_io_in_o[4:2]
//   cmd_reset_i    1 = hold DUT reset (dut_io_in_o[1]=0) for the whole command
//   cmd_pulses_i   number of DUT clock pulses; 0 = sample only
//   rsp_valid_o    response byte available
//   rsp_ready_i    response consumed on rsp_valid_o & rsp_ready_i
//   rsp_data_o     sampled DUT output byte
//   busy_o         high in every state except idle
//   dut_io_in_o    registered pin word to the wrapper
//   dut_io_out_i   wrapper output pins, asynchronous to clk_i
// ---------------------------------------------------------------------------------------------
module tt_host_pin_driver #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_sel_i,
    input  logic [2:0]       cmd_data_i,
    input  logic             cmd_reset_i,
    input  logic [CNT_W-1:0] cmd_pulses_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [7:0]       rsp_data_o,
    output logic             busy_o,
    output logic [7:0]       dut_io_in_o,
    input  logic [7:0]       dut_io_out_i
);

    localparam int unsigned DivW = $clog2(CLK_DIV + 1);
    // Divider counts down to zero, so a phase of CLK_DIV cycles loads CLK_DIV-1.
    localparam logic [DivW-1:0] DivLoad    = DivW'(CLK_DIV - 1);
    // Two cycles in SAMPLE let the synchronizer flush the last pin change.
    localparam logic [DivW-1:0] SampleLoad = DivW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StClkHi,
        StClkLo,
        StSample,
        StResp
    } state_e;

    state_e           state_q;
    logic [DivW-1:0]  div_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       sel_q;
    logic [2:0]       data_q;
    logic [7:0]       pins_q;
    logic             cmd_ready_q;
    logic             rsp_valid_q;
    logic [7:0]       rsp_data_q;
    logic [7:0]       sync1_q;
    logic [7:0]       sync2_q;

    // Wrapper outputs are asynchronous; only sync2_q is ever captured.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 8'h00;
            sync2_q <= 8'h00;
        end else begin
            sync1_q <= dut_io_out_i;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            div_q       <= '0;
            cnt_q       <= '0;
            sel_q       <= 3'd0;
            data_q      <= 3'd0;
            pins_q      <= 8'h00;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Idle pin word keeps the last select/data with the DUT out of reset.
                    cmd_ready_q <= 1'b1;
                    pins_q      <= {sel_q, data_q, 2'b10};
                    if (cmd_valid_i && cmd_ready_q) begin
                        sel_q       <= cmd_sel_i;
                        data_q      <= cmd_data_i;
                        cnt_q       <= cmd_pulses_i;
                        pins_q      <= {cmd_sel_i, cmd_data_i, ~cmd_reset_i, 1'b0};
                        div_q       <= DivLoad;
                        cmd_ready_q <= 1'b0;
                        state_q     <= StSetup;
                    end
                end
                StSetup: begin
                    if (div_q == '0) begin
                        if (cnt_q != '0) begin
                            pins_q[0] <= 1'b1;
                            div_q     <= DivLoad;
                            state_q   <= StClkHi;
                        end else begin
                            div_q   <= SampleLoad;
                            state_q <= StSample;
                        end
                    end else begin
                        div_q <= div_q - 1'b1;
                    end
                end
                StClkHi: begin
                    if (div_q == '0) begin
                        pins_q[0] <= 1'b0;
                        div_q     <= DivLoad;
                        state_q   <= StClkLo;
                    end else begin
                        div_q <= div_q - 1'b1;
                    end
                end
                StClkLo: begin
                    if (div_q == '0) begin
                        // cnt_q is non-zero here, so the decrement never wraps.
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            div_q   <= SampleLoad;
                            state_q <= StSample;
                        end else begin
                            pins_q[0] <= 1'b1;
                            div_q     <= DivLoad;
                            state_q   <= StClkHi;
                        end
                    end else begin
                        div_q <= div_q - 1'b1;
                    end
                end
                StSample: begin
                    if (div_q == '0) begin
                        rsp_data_q  <= sync2_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end else begin
                        div_q <= div_q - 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        // DUT reset is released only now, after the sample was taken.
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        pins_q      <= {sel_q, data_q, 2'b10};
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign busy_o      = (state_q != StIdle);
    assign dut_io_in_o = pins_q;

endmodule
